// File: rtl/sprite_loader_if.sv
// UART-byte-in / sprite-RAM-write-out bundle for sprite_loader.
// The loader is the slave side; the UART feed plus RAM/status observer is the master side.
interface sprite_loader_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  i_Rx_DV;
  logic [7:0]            i_Rx_Byte;
  logic                  o_Wr_En;
  logic                  o_Wr_Sel;
  logic [ADDR_WIDTH-1:0] o_Wr_Addr;
  logic [8:0]            o_Wr_Data;
  logic                  o_Busy;
  logic                  o_Done;
  logic                  o_Error;

  modport master (
    output i_Rx_DV, i_Rx_Byte,
    input  o_Wr_En, o_Wr_Sel, o_Wr_Addr, o_Wr_Data, o_Busy, o_Done, o_Error
  );

  modport slave (
    input  i_Rx_DV, i_Rx_Byte,
    output o_Wr_En, o_Wr_Sel, o_Wr_Addr, o_Wr_Data, o_Busy, o_Done, o_Error
  );
endinterface

// File: rtl/sprite_loader.sv
// Turns a UART byte stream (header 0xA0|sel, then hi/lo pixel pairs) into RGB333 sprite RAM writes.
// Define SPRITE_LOADER_CHECKSUM_EN to require a trailing XOR byte over all pixel bytes.
module sprite_loader #(
  parameter int TILE_SIZE      = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int TIMEOUT_CYCLES = 2500000
) (
  input  logic           i_Clk,
  input  logic           i_Rst_L,
  sprite_loader_if.slave bus
);

  localparam int                    N_PIX     = TILE_SIZE * TILE_SIZE;
  localparam int                    TMO_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(N_PIX - 1);
  localparam logic [TMO_W-1:0]      TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);

`ifdef SPRITE_LOADER_CHECKSUM_EN
  typedef enum logic [1:0] {S_IDLE, S_PIX_HI, S_PIX_LO, S_CHECK} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_PIX_HI, S_PIX_LO} state_t;
`endif

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pix_cnt_q;
  logic [TMO_W-1:0]      tmo_cnt_q;
  logic                  hi_bit_q;
  logic                  wr_en_d, done_d, error_d;
  logic                  hdr_byte, last_pix, tmo_hit;

`ifdef SPRITE_LOADER_CHECKSUM_EN
  logic [7:0] csum_q;
  logic       csum_ok;
  assign csum_ok = (bus.i_Rx_Byte == csum_q);
`endif

  assign hdr_byte = (bus.i_Rx_Byte[7:1] == 7'b1010_000);
  assign last_pix = (pix_cnt_q == LAST_ADDR);
  // A byte on the expiry cycle keeps the frame alive.
  assign tmo_hit  = (state_q != S_IDLE) && !bus.i_Rx_DV && (tmo_cnt_q == TMO_LAST);
  assign bus.o_Busy = (state_q != S_IDLE);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // NOTE: every combinational output gets a default first, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    if (tmo_hit) begin
      state_d = S_IDLE;
    end else if (bus.i_Rx_DV) begin
      case (state_q)
        S_IDLE:   if (hdr_byte) state_d = S_PIX_HI;
        S_PIX_HI: state_d = S_PIX_LO;
        S_PIX_LO: begin
          if (!last_pix)
            state_d = S_PIX_HI;
          else
`ifdef SPRITE_LOADER_CHECKSUM_EN
            state_d = S_CHECK;
`else
            state_d = S_IDLE;
`endif
        end
        default:  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_en_d = bus.i_Rx_DV && (state_q == S_PIX_LO);
`ifdef SPRITE_LOADER_CHECKSUM_EN
    done_d  = bus.i_Rx_DV && (state_q == S_CHECK) && csum_ok;
    error_d = tmo_hit || (bus.i_Rx_DV && (state_q == S_CHECK) && !csum_ok);
`else
    done_d  = wr_en_d && last_pix;
    error_d = tmo_hit;
`endif
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      bus.o_Wr_En   <= 1'b0;
      bus.o_Wr_Sel  <= 1'b0;
      bus.o_Wr_Addr <= '0;
      bus.o_Wr_Data <= '0;
      bus.o_Done    <= 1'b0;
      bus.o_Error   <= 1'b0;
      pix_cnt_q     <= '0;
      tmo_cnt_q     <= '0;
      hi_bit_q      <= 1'b0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
      csum_q        <= '0;
`endif
    end else begin
      bus.o_Wr_En <= wr_en_d;
      bus.o_Done  <= done_d;
      bus.o_Error <= error_d;

      if (bus.i_Rx_DV || tmo_hit || (state_q == S_IDLE)) tmo_cnt_q <= '0;
      else                                               tmo_cnt_q <= tmo_cnt_q + TMO_W'(1);

      if (bus.i_Rx_DV) begin
        case (state_q)
          S_IDLE: begin
            if (hdr_byte) begin
              bus.o_Wr_Sel <= bus.i_Rx_Byte[0];
              pix_cnt_q    <= '0;
`ifdef SPRITE_LOADER_CHECKSUM_EN
              csum_q       <= '0;
`endif
            end
          end
          S_PIX_HI: begin
            hi_bit_q <= bus.i_Rx_Byte[0];
`ifdef SPRITE_LOADER_CHECKSUM_EN
            csum_q   <= csum_q ^ bus.i_Rx_Byte;
`endif
          end
          S_PIX_LO: begin
            bus.o_Wr_Addr <= pix_cnt_q;
            bus.o_Wr_Data <= {hi_bit_q, bus.i_Rx_Byte};
            // Hold at the final address so a 2**ADDR_WIDTH == N_PIX build never wraps.
            if (!last_pix) pix_cnt_q <= pix_cnt_q + ADDR_WIDTH'(1);
`ifdef SPRITE_LOADER_CHECKSUM_EN
            csum_q        <= csum_q ^ bus.i_Rx_Byte;
`endif
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_sprite_loader.sv
// Directed bench for sprite_loader: scoreboard of expected RAM writes plus done/error pulse accounting.
module tb_sprite_loader;

  localparam int TILE = 32;
  localparam int AW   = 10;
  localparam int T    = 100;
  localparam int NPIX = TILE * TILE;

  typedef struct packed {
    logic          sel;
    logic [AW-1:0] addr;
    logic [8:0]    data;
  } wr_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sprite_loader_if #(.ADDR_WIDTH(AW)) bus ();

  sprite_loader #(
    .TILE_SIZE     (TILE),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .bus    (bus)
  );

  wr_t exp_q[$];
  int  checks   = 0;
  int  errors   = 0;
  int  wr_count = 0;
  int  done_cnt = 0;
  int  err_cnt  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Output monitor: pops the scoreboard on each write and tallies end-of-frame pulses.
  always @(negedge clk) begin
    wr_t e;
    if (rst_n) begin
      if (bus.o_Wr_En) begin
        wr_count++;
        check("sb_has_entry", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          check("wr_sel",  bus.o_Wr_Sel,  e.sel);
          check("wr_addr", bus.o_Wr_Addr, e.addr);
          check("wr_data", bus.o_Wr_Data, e.data);
        end
      end
      if (bus.o_Done || bus.o_Error) begin
        check("done_err_excl", bus.o_Done & bus.o_Error, 0);
        check("busy_at_end", bus.o_Busy, 0);
      end
      if (bus.o_Done) begin
        done_cnt++;
`ifndef SPRITE_LOADER_CHECKSUM_EN
        check("done_with_last_wr", {bus.o_Wr_En, bus.o_Wr_Addr}, {1'b1, AW'(NPIX - 1)});
`endif
      end
      if (bus.o_Error) err_cnt++;
    end
  end

  // Called at a negedge; the byte is sampled on the next posedge and the next call lands gap cycles later.
  task automatic send_byte(input logic [7:0] b, input int gap);
    bus.i_Rx_DV   = 1'b1;
    bus.i_Rx_Byte = b;
    @(negedge clk);
    bus.i_Rx_DV   = 1'b0;
    repeat (gap - 1) @(negedge clk);
  endtask

  task automatic send_pixel(input logic sel, input int addr, input logic [7:0] hi,
                            input logic [7:0] lo, input int gap);
    exp_q.push_back({sel, AW'(addr), hi[0], lo});
    send_byte(hi, gap);
    send_byte(lo, 1);
    check("wr_latency", bus.o_Wr_En, 1);
    repeat (gap - 1) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not reach its end");
    $fatal(1);
  end

  initial begin
    int   base_wr;
    logic early;
    logic [7:0] hi, lo, csum;

    bus.i_Rx_DV   = 1'b0;
    bus.i_Rx_Byte = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_wr_en", bus.o_Wr_En, 0);
    check("rst_sel",   bus.o_Wr_Sel, 0);
    check("rst_addr",  bus.o_Wr_Addr, 0);
    check("rst_data",  bus.o_Wr_Data, 0);
    check("rst_flags", {bus.o_Busy, bus.o_Done, bus.o_Error}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full car frame, one byte every 10 cycles.
    send_byte(8'hA1, 10);
    check("t1_busy_after_hdr", bus.o_Busy, 1);
    for (int i = 0; i < NPIX; i++) send_pixel(1'b1, i, 8'h01, 8'hFF, 10);
`ifdef SPRITE_LOADER_CHECKSUM_EN
    send_byte(8'h00, 10);
`endif
    repeat (5) @(negedge clk);
    check("t1_writes",    wr_count, NPIX);
    check("t1_done",      done_cnt, 1);
    check("t1_err",       err_cnt, 0);
    check("t1_busy",      bus.o_Busy, 0);
    check("t1_drained",   exp_q.size(), 0);
    check("t1_addr_hold", bus.o_Wr_Addr, NPIX - 1);
    check("t1_data_hold", bus.o_Wr_Data, 9'h1FF);

    // Junk bytes in IDLE, then a frog frame that is left to time out.
    base_wr = wr_count;
    send_byte(8'h55, 3);
    check("t2_busy_55", bus.o_Busy, 0);
    send_byte(8'h00, 3);
    check("t2_busy_00", bus.o_Busy, 0);
    send_byte(8'hFF, 3);
    check("t2_busy_ff", bus.o_Busy, 0);
    check("t2_no_wr", wr_count, base_wr);
    send_byte(8'hA0, 3);
    send_pixel(1'b0, 0, 8'h00, 8'h3C, 3);
    repeat (T + 10) @(negedge clk);
    check("t2_tmo_err", err_cnt, 1);
    check("t2_drained", exp_q.size(), 0);
    check("t2_busy",    bus.o_Busy, 0);

    // Exact timeout position after five pairs.
    send_byte(8'hA0, 2);
    for (int i = 0; i < 4; i++) send_pixel(1'b0, i, 8'(i), 8'(8'h10 + i), 2);
    exp_q.push_back({1'b0, AW'(4), 1'b0, 8'h14});
    send_byte(8'h04, 2);
    send_byte(8'h14, 1);
    check("t3_last_wr", bus.o_Wr_En, 1);
    early = 1'b0;
    for (int k = 1; k < T; k++) begin
      @(negedge clk);
      if (bus.o_Error) early = 1'b1;
    end
    check("t3_no_early_err", early, 0);
    @(negedge clk);
    check("t3_err_at_T", bus.o_Error, 1);
    check("t3_busy",     bus.o_Busy, 0);
    @(negedge clk);
    check("t3_err_pulse", bus.o_Error, 0);
    check("t3_err_cnt",   err_cnt, 2);

    // New frame restarts at addr 0; a byte on the expiry cycle suppresses the timeout.
    send_byte(8'hA1, 2);
    exp_q.push_back({1'b1, AW'(0), 1'b1, 8'hAB});
    send_byte(8'h01, 2);
    send_byte(8'hAB, T);
    send_byte(8'h00, 2);
    check("t5_no_err", err_cnt, 2);
    check("t5_busy",   bus.o_Busy, 1);
    exp_q.push_back({1'b1, AW'(1), 1'b0, 8'h5A});
    send_byte(8'h5A, 1);
    check("t5_wr_continue", bus.o_Wr_En, 1);
    repeat (3) @(negedge clk);
    check("t5_drained", exp_q.size(), 0);
    repeat (T + 10) @(negedge clk);
    check("t5_tmo_later", err_cnt, 3);

    // Reset while pixel 300 is being written.
    send_byte(8'hA1, 2);
    for (int i = 0; i < 300; i++) send_pixel(1'b1, i, 8'(i >> 8), 8'(i), 2);
    exp_q.push_back({1'b1, AW'(300), 1'b1, 8'h2C});
    send_byte(8'h01, 2);
    send_byte(8'h2C, 1);
    check("t4_wr_before_rst", bus.o_Wr_En, 1);
    #2 rst_n = 1'b0;
    #1;
    check("t4_rst_wr_en", bus.o_Wr_En, 0);
    check("t4_rst_sel",   bus.o_Wr_Sel, 0);
    check("t4_rst_addr",  bus.o_Wr_Addr, 0);
    check("t4_rst_data",  bus.o_Wr_Data, 0);
    check("t4_rst_flags", {bus.o_Busy, bus.o_Done, bus.o_Error}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("t4_no_done", done_cnt, 1);
    check("t4_no_err",  err_cnt, 3);
    check("t4_drained", exp_q.size(), 0);
    send_byte(8'hA1, 2);
    send_pixel(1'b1, 0, 8'h01, 8'hC3, 2);
    send_pixel(1'b1, 1, 8'h00, 8'h3C, 2);
    repeat (T + 10) @(negedge clk);
    check("t4_fresh_drained", exp_q.size(), 0);
    check("t4_fresh_tmo",     err_cnt, 4);

`ifdef SPRITE_LOADER_CHECKSUM_EN
    // Checksum: good byte completes, flipped byte aborts, writes happen either way.
    base_wr = wr_count;
    for (int f = 0; f < 2; f++) begin
      csum = 8'h00;
      send_byte(8'hA0, 2);
      for (int i = 0; i < NPIX; i++) begin
        hi   = 8'(i * 3);
        lo   = 8'(i * 37 + 5);
        csum = csum ^ hi ^ lo;
        send_pixel(1'b0, i, hi, lo, 2);
      end
      send_byte((f == 0) ? csum : (csum ^ 8'h01), 2);
      repeat (3) @(negedge clk);
      check("t6_done_cnt", done_cnt, 2);
      check("t6_err_cnt",  err_cnt, 4 + f);
      check("t6_busy",     bus.o_Busy, 0);
    end
    check("t6_writes", wr_count - base_wr, 2 * NPIX);
`endif

    check("final_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sprite_loader.md
Name: sprite_loader

Overview:
- Writer side of the sprite memories: receives a sprite image as a UART byte stream and writes 9-bit RGB333 pixels into the frog or car sprite RAM write port.
- Sits between the UART receiver (byte + data-valid strobe) and the write ports of the sprite Memory instances.
- Allows sprites to be replaced at runtime without resynthesis.

Parameters:
- TILE_SIZE, 32, sprite edge in pixels; a frame is TILE_SIZE*TILE_SIZE pixels.
- ADDR_WIDTH, 10, write address width; must satisfy 2**ADDR_WIDTH >= TILE_SIZE*TILE_SIZE.
- TIMEOUT_CYCLES, 2500000, maximum idle clock cycles between bytes inside a frame before the frame is aborted.

Ports:
- i_Clk  input  1  system clock.
- i_Rst_L  input  1  asynchronous, active-low reset.
- i_Rx_DV  input  1  one-cycle strobe: i_Rx_Byte is valid.
- i_Rx_Byte  input  8  received byte.
- o_Wr_En  output  1  one-cycle sprite RAM write strobe.
- o_Wr_Sel  output  1  target memory: 0 = frog, 1 = car.
- o_Wr_Addr  output  ADDR_WIDTH  pixel address, row-major: y*TILE_SIZE + x.
- o_Wr_Data  output  9  pixel, {R[2:0],G[2:0],B[2:0]}.
- o_Busy  output  1  high while a frame is in progress.
- o_Done  output  1  one-cycle pulse: frame completed successfully.
- o_Error  output  1  one-cycle pulse: frame aborted.

Behaviour:
- Reset (asynchronous, active-low): state IDLE; all outputs 0; pixel counter 0; timeout counter 0.
- Frame format: header byte 0xA0 | sel (0xA0 = frog, 0xA1 = car), then TILE_SIZE*TILE_SIZE pixel pairs.
  - Each pair is a high byte (bit0 = pixel[8], bits[7:1] ignored) followed by a low byte (pixel[7:0]).
- States: IDLE, PIX_HI, PIX_LO, CHECK (present only with the optional feature).
- IDLE:
  - A byte of 0xA0 or 0xA1 latches o_Wr_Sel, clears the pixel counter, sets o_Busy and moves to PIX_HI.
  - All other bytes are ignored; no error is raised.
- PIX_HI: a byte stores bit0 in a holding register and moves to PIX_LO.
- PIX_LO: a byte causes the following on the next cycle:
  - o_Wr_En = 1 for exactly one cycle.
  - o_Wr_Addr = current pixel counter.
  - o_Wr_Data = {held bit, byte}.
  - The counter then increments.
  - Latency: o_Wr_En is asserted exactly 1 cycle after the i_Rx_DV of the low byte.
  - o_Wr_Addr and o_Wr_Data hold their values until the next write.
- Last pixel (counter = TILE_SIZE*TILE_SIZE-1):
  - Without the feature: after the write, go to IDLE, pulse o_Done in the same cycle as the final o_Wr_En, and drop o_Busy that cycle.
  - With the feature: go to CHECK.
- Counter arithmetic: ADDR_WIDTH bits, never wraps within a frame. The final address is TILE_SIZE*TILE_SIZE-1.
- Timeout:
  - The counter resets on every i_Rx_DV and counts only while o_Busy = 1.
  - On reaching TIMEOUT_CYCLES: pulse o_Error, go to IDLE, clear o_Busy.
  - Pixels already written are not rolled back.
- Header bytes inside a frame are treated as pixel data; there is no resynchronisation mid-frame.
- i_Rx_DV on the same cycle as a timeout expiry: the byte wins; the timeout is suppressed.
- Reset asserted mid-frame: immediate return to IDLE. No o_Done/o_Error pulse. o_Wr_En is forced low asynchronously.
- o_Done and o_Error are never asserted together.

Optional Feature:
- Macro: SPRITE_LOADER_CHECKSUM_EN.
- Defined:
  - After the last pixel, the FSM enters CHECK and expects one byte equal to the XOR of all 2*TILE_SIZE*TILE_SIZE pixel bytes (header excluded).
  - Match: pulse o_Done. Mismatch: pulse o_Error.
  - Either way, the pulse is 1 cycle after that byte's i_Rx_DV, then IDLE with o_Busy low.
  - The timeout also applies in CHECK.
- Undefined: no CHECK state and no XOR register; the frame ends on the last pixel write as described above.

Test Plan:
- Reset, send 0xA1 then 1024 pairs (0x01,0xFF) at 1 byte per 10 cycles -> 1024 writes with o_Wr_Sel = 1, addresses 0..1023 in order, data 9'h1FF; o_Done pulses once (after a checksum byte 0x00 if the macro is defined); o_Busy low afterwards.
- Bytes 0x55, 0x00, 0xFF in IDLE -> no o_Wr_En, o_Busy stays 0; then 0xA0, 0x00, 0x3C -> write addr 0, data 9'h03C, o_Wr_Sel = 0.
- Send 0xA0 plus 5 pairs, then idle for TIMEOUT_CYCLES (bench override = 100) -> o_Error pulses on cycle 100 after the last byte; the next 0xA1 starts a new frame at addr 0.
- Assert i_Rst_L = 0 during pixel 300 -> all outputs 0 asynchronously, no o_Done or o_Error; a fresh frame afterwards starts at addr 0.
- Byte arriving on the exact cycle the timeout would expire -> no o_Error; the frame continues.
- With SPRITE_LOADER_CHECKSUM_EN: full frame with a correct XOR byte -> o_Done; the same frame with the checksum byte XOR 0x01 -> o_Error, and all 1024 writes still occurred.
